audio_i2s_out: RTL and testbench

//  I2S serializer for the core's audio path. Runs on the 12.288 MHz audio clock from the core PLL.

---
 rtl/audio_i2s_out_if.sv | 13 +
 rtl/audio_i2s_out.sv | 119 +++++++++++
 tb/tb_audio_i2s_out.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_i2s_out_if.sv
// Sample-pair handshake into the I2S serializer: the producer holds a stereo
// pair on in_left/in_right and it is taken on any clk where in_valid & in_ready.
interface audio_i2s_out_if #(
    parameter int SAMPLE_W = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [SAMPLE_W-1:0] in_left;
    logic [SAMPLE_W-1:0] in_right;

    modport master (output in_valid, output in_left, output in_right, input in_ready);
    modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/audio_i2s_out.sv
// I2S transmitter: small stereo FIFO feeding a fixed 64-SCLK frame (SCLK = clk/4),
// MSB one SCLK after each LRCK edge, each channel zero-padded to a 32-bit slot.
module audio_i2s_out #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_audio,
    input  logic                          reset_n,
    audio_i2s_out_if.slave                in_if,
    output logic                          audio_sclk,
    output logic                          audio_lrck,
    output logic                          audio_dac,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [2*SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [LW-1:0]         level_reg;

    logic [1:0]            div_reg;
    logic [5:0]            bit_cnt_reg;
    logic [SAMPLE_W-1:0]   left_reg;
    logic [SAMPLE_W-1:0]   right_reg;
    logic                  sclk_reg;
    logic                  lrck_reg;
    logic                  dac_reg;
    logic                  underrun_reg;

    logic [1:0]            div_next;
    logic [5:0]            bit_cnt_next;
    logic                  tick;
    logic                  load;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [31:0]           slot_left;
    logic [31:0]           slot_right;
    logic                  dac_next;

    assign div_next     = div_reg + 2'd1;
    assign bit_cnt_next = bit_cnt_reg + 6'd1;
    assign tick         = (div_reg == 2'd3);
    assign load         = tick && (bit_cnt_reg == 6'd63);
    assign fifo_empty   = (level_reg == '0);
    assign in_if.in_ready = (level_reg != LW'(FIFO_DEPTH));
    assign push         = in_if.in_valid && in_if.in_ready;
    assign pop          = load && !fifo_empty;

    // Sample MSB lands on slot bit 30, so slot bit b is found at index 31-b:
    // b=0 (the LRCK-edge bit) and everything past the LSB read as zero.
    assign slot_left  = 32'(left_reg)  << (31 - SAMPLE_W);
    assign slot_right = 32'(right_reg) << (31 - SAMPLE_W);
    assign dac_next   = bit_cnt_next[5] ? slot_right[~bit_cnt_next[4:0]]
                                        : slot_left[~bit_cnt_next[4:0]];

    always_ff @(posedge clk_audio) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_if.in_left, in_if.in_right};
        end
    end

    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) begin
            div_reg      <= '0;
            bit_cnt_reg  <= '0;
            left_reg     <= '0;
            right_reg    <= '0;
            sclk_reg     <= 1'b0;
            lrck_reg     <= 1'b0;
            dac_reg      <= 1'b0;
            underrun_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
        end else begin
            div_reg      <= div_next;
            sclk_reg     <= div_next[1];
            underrun_reg <= load && fifo_empty;

            // Serial outputs move together on the SCLK falling edge.
            if (tick) begin
                bit_cnt_reg <= bit_cnt_next;
                lrck_reg    <= bit_cnt_next[5];
                dac_reg     <= dac_next;
            end

            if (load) begin
                if (!fifo_empty) begin
                    {left_reg, right_reg} <= mem[rd_ptr_reg];
                end else begin
                    left_reg  <= '0;
                    right_reg <= '0;
                end
            end

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign audio_sclk = sclk_reg;
    assign audio_lrck = lrck_reg;
    assign audio_dac  = dac_reg;
    assign underrun   = underrun_reg;
    assign fifo_level = level_reg;
endmodule

// File: tb/tb_audio_i2s_out.sv
// Bench for audio_i2s_out: a reference FIFO/frame-load model fills a scoreboard of
// expected frames, and each scenario task captures DAC frames and checks them inline.
`timescale 1ns/1ps
module tb_audio_i2s_out;
    localparam int SW    = 16;
    localparam int DEPTH = 4;

    logic       clk_audio = 1'b0;
    logic       reset_n   = 1'b0;
    logic       audio_sclk;
    logic       audio_lrck;
    logic       audio_dac;
    logic       underrun;
    logic [2:0] fifo_level;

    audio_i2s_out_if #(.SAMPLE_W(SW)) bus ();

    audio_i2s_out #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_audio  (clk_audio),
        .reset_n    (reset_n),
        .in_if      (bus),
        .audio_sclk (audio_sclk),
        .audio_lrck (audio_lrck),
        .audio_dac  (audio_dac),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    always #40 clk_audio = ~clk_audio;

    typedef struct {
        int          frame;
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        bit          under;
    } sb_t;

    sb_t           sb_q[$];
    logic [2*SW-1:0] model_q[$];
    int            edge_n;
    int            n_checks = 0;
    int            n_fail   = 0;

    // Clock edges counted since reset release; edge n has div=n%4, bit=(n/4)%64.
    always @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) edge_n <= 0;
        else          edge_n <= edge_n + 1;
    end

    // Reference model: frame loads on every 256th edge, FIFO with no bypass.
    always @(posedge clk_audio or negedge reset_n) begin : model
        sb_t e;
        bit  acc;
        if (!reset_n) begin
            model_q.delete();
            sb_q.delete();
        end else begin
            acc = bus.in_valid && (model_q.size() < DEPTH);
            if ((edge_n + 1) % 256 == 0) begin
                e.frame = (edge_n + 1) / 256;
                if (model_q.size() > 0) begin
                    {e.l, e.r} = model_q.pop_front();
                    e.under = 1'b0;
                end else begin
                    e.l = '0;
                    e.r = '0;
                    e.under = 1'b1;
                end
                sb_q.push_back(e);
            end
            if (acc) model_q.push_back({bus.in_left, bus.in_right});
        end
    end

    function automatic logic [63:0] frame_bits(input logic [SW-1:0] l, input logic [SW-1:0] r);
        return {1'b0, l, {(31-SW){1'b0}}, 1'b0, r, {(31-SW){1'b0}}};
    endfunction

    task automatic wait_edge(input int n);
        for (int t = 0; t < 20000 && edge_n < n; t++) @(negedge clk_audio);
    endtask

    task automatic do_reset();
        @(negedge clk_audio);
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk_audio);
        reset_n = 1'b1;
    endtask

    task automatic push_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
        bus.in_valid = 1'b1;
        bus.in_left  = l;
        bus.in_right = r;
        @(negedge clk_audio);
        bus.in_valid = 1'b0;
    endtask

    // Collects dac/lrck at each SCLK rise of frame f; bit b stored at index 63-b.
    task automatic capture_frame(input int f, output logic [63:0] dac_bits,
                                 output logic [63:0] lrck_bits, output bit ok);
        int tgt;
        ok = 1'b1;
        dac_bits  = '0;
        lrck_bits = '0;
        for (int b = 0; b < 64; b++) begin
            tgt = 256 * f + 4 * b + 2;
            wait_edge(tgt);
            if (edge_n != tgt) ok = 1'b0;
            dac_bits[63-b]  = audio_dac;
            lrck_bits[63-b] = audio_lrck;
        end
    endtask

    task automatic sb_fetch(input int f, output sb_t e, output bit found);
        found = 1'b0;
        e = '{frame: -1, l: '0, r: '0, under: 1'b0};
        while (sb_q.size() > 0 && sb_q[0].frame < f) void'(sb_q.pop_front());
        if (sb_q.size() > 0 && sb_q[0].frame == f) begin
            e = sb_q.pop_front();
            found = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        @(negedge clk_audio);
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'($urandom);
            bus.in_left  = SW'($urandom);
            bus.in_right = SW'($urandom);
            @(negedge clk_audio);
            obs = {audio_sclk, audio_lrck, audio_dac, underrun, fifo_level, bus.in_ready};
            n_checks++;
            if (obs !== 8'b0000_000_1) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %b want 00000001", i, obs);
            end
        end
        bus.in_valid = 1'b0;
        reset_n = 1'b1;
        wait_edge(1);
        n_checks++;
        if (audio_sclk !== 1'b0 || edge_n != 1) begin
            n_fail++;
            $display("FAIL reset_release_sclk_clk1: got %b want 0", audio_sclk);
        end
        wait_edge(2);
        n_checks++;
        if (audio_sclk !== 1'b1 || edge_n != 2) begin
            n_fail++;
            $display("FAIL reset_release_sclk_clk2: got %b want 1", audio_sclk);
        end
        $display("test_reset done");
    endtask

    task automatic test_free_run();
        int sclk_bad = 0, lrck_bad = 0, ur_bad = 0, n;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_audio);
            n = edge_n;
            if (audio_sclk !== ((n % 4) >= 2)) sclk_bad++;
            if (audio_lrck !== (((n / 4) % 64) >= 32)) lrck_bad++;
            if (underrun !== ((n % 256 == 0) && n > 0)) ur_bad++;
        end
        n_checks++;
        if (sclk_bad != 0) begin
            n_fail++;
            $display("FAIL free_run_sclk: %0d bad cycles, want 0", sclk_bad);
        end
        n_checks++;
        if (lrck_bad != 0) begin
            n_fail++;
            $display("FAIL free_run_lrck: %0d bad cycles, want 0", lrck_bad);
        end
        n_checks++;
        if (ur_bad != 0) begin
            n_fail++;
            $display("FAIL free_run_underrun: %0d bad cycles, want 0", ur_bad);
        end
        $display("test_free_run done: %0d cycles", 600);
    endtask

    task automatic test_single_sample();
        logic [63:0] d, lr;
        bit ok, found;
        sb_t e;
        do_reset();
        push_pair(16'hA5C3, 16'h0F0F);
        n_checks++;
        if (fifo_level !== 3'd1) begin
            n_fail++;
            $display("FAIL single_level: got %0d want 1", fifo_level);
        end
        capture_frame(1, d, lr, ok);
        sb_fetch(1, e, found);
        n_checks++;
        if (!ok || !found) begin
            n_fail++;
            $display("FAIL single_capture: ok=%0b sb_found=%0b want 1/1", ok, found);
        end
        n_checks++;
        if (d !== 64'h52E1_8000_0787_8000) begin
            n_fail++;
            $display("FAIL single_dac: got %h want 52e18000_07878000", d);
        end
        n_checks++;
        if (d !== frame_bits(e.l, e.r) || e.under) begin
            n_fail++;
            $display("FAIL single_scoreboard: got %h want %h", d, frame_bits(e.l, e.r));
        end
        n_checks++;
        if (lr !== 64'h0000_0000_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL single_lrck: got %h want 00000000ffffffff", lr);
        end
        $display("test_single_sample: frame1 dac=%h", d);
    endtask

    logic [SW-1:0] bb_l [5] = '{16'h1234, 16'h8001, 16'hFFFF, 16'h7FFE, 16'hDEAD};
    logic [SW-1:0] bb_r [5] = '{16'hCAFE, 16'h0001, 16'h8000, 16'h5555, 16'hBEEF};

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_left  = bb_l[k];
            bus.in_right = bb_r[k];
            n_checks++;
            if (bus.in_ready !== (k < 4)) begin
                n_fail++;
                $display("FAIL b2b_ready push %0d: got %b want %b", k, bus.in_ready, (k < 4));
            end
            @(negedge clk_audio);
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd4 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: level=%0d ready=%b want 4/0", fifo_level, bus.in_ready);
        end
        wait_edge(257);
        n_checks++;
        if (fifo_level !== 3'd3 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_after_load: level=%0d ready=%b want 3/1", fifo_level, bus.in_ready);
        end
        $display("test_back_to_back: 5 offered, level after load %0d", fifo_level);
    endtask

    task automatic test_underrun();
        logic [63:0] d, lr;
        bit ok, found;
        sb_t e;
        for (int f = 1; f <= 4; f++) begin
            capture_frame(f, d, lr, ok);
            sb_fetch(f, e, found);
            n_checks++;
            if (!ok || !found || d !== frame_bits(bb_l[f-1], bb_r[f-1]) || d !== frame_bits(e.l, e.r)) begin
                n_fail++;
                $display("FAIL drain_frame%0d: got %h want %h", f, d, frame_bits(bb_l[f-1], bb_r[f-1]));
            end
        end
        for (int n = 1279; n <= 1281; n++) begin
            wait_edge(n);
            n_checks++;
            if (underrun !== (n == 1280)) begin
                n_fail++;
                $display("FAIL underrun_pulse edge %0d: got %b want %b", n, underrun, (n == 1280));
            end
        end
        push_pair(16'h0C0C, 16'hF00D);
        capture_frame(5, d, lr, ok);
        sb_fetch(5, e, found);
        n_checks++;
        if (!ok || !found || !e.under || d !== 64'h0) begin
            n_fail++;
            $display("FAIL underrun_frame_mute: got %h under=%b want 0 under=1", d, e.under);
        end
        capture_frame(6, d, lr, ok);
        sb_fetch(6, e, found);
        n_checks++;
        if (!ok || !found || d !== frame_bits(16'h0C0C, 16'hF00D) || d !== frame_bits(e.l, e.r)) begin
            n_fail++;
            $display("FAIL underrun_recover: got %h want %h", d, frame_bits(16'h0C0C, 16'hF00D));
        end
        $display("test_underrun: frame6 dac=%h", d);
    endtask

    task automatic test_reset_mid();
        logic [63:0] d0, d1, lr;
        bit ok0, ok1;
        logic [7:0] obs;
        do_reset();
        for (int k = 0; k < 4; k++) push_pair(bb_l[k] ^ 16'h3C3C, bb_r[k] ^ 16'hA5A5);
        wait_edge(256 + 4 * 40 + 1);
        n_checks++;
        if (fifo_level !== 3'd3 || audio_lrck !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: level=%0d lrck=%b want 3/1", fifo_level, audio_lrck);
        end
        reset_n = 1'b0;
        @(negedge clk_audio);
        obs = {audio_sclk, audio_lrck, audio_dac, underrun, fifo_level, bus.in_ready};
        n_checks++;
        if (obs !== 8'b0000_000_1) begin
            n_fail++;
            $display("FAIL midreset_hold: got %b want 00000001", obs);
        end
        reset_n = 1'b1;
        wait_edge(2);
        n_checks++;
        if (audio_sclk !== 1'b1 || audio_lrck !== 1'b0 || edge_n != 2) begin
            n_fail++;
            $display("FAIL midreset_restart: sclk=%b lrck=%b want 1/0", audio_sclk, audio_lrck);
        end
        capture_frame(0, d0, lr, ok0);
        wait_edge(256);
        n_checks++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_underrun: got %b want 1", underrun);
        end
        capture_frame(1, d1, lr, ok1);
        n_checks++;
        if (!ok0 || !ok1 || d0 !== 64'h0 || d1 !== 64'h0 || fifo_level !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_flush: f0=%h f1=%h level=%0d want 0/0/0", d0, d1, fifo_level);
        end
        $display("test_reset_mid: frames after reset %h %h", d0, d1);
    endtask

    initial begin
        #(80 * 30000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_left  = '0;
        bus.in_right = '0;
        test_reset();
        test_free_run();
        test_single_sample();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
